m3_cmd_key_gen: RTL and testbench
=================================

Name: m3_cmd_key_gen

Overview:
- Front-panel command generator for the 3-phase motor controller.
- Synchronises, debounces and edge-detects seven raw push-buttons.
- Produces the m3 command signals consumed by the power/speed calculation block:
  - start level
  - forceStop pulse
  - invRotate level
  - freq INC/DEC pulses and power INC/DEC pulses, each with auto-repeat while held.

Parameters:
- DEB_CYCLES, 1000: consecutive stable cycles needed to accept a key state change (minimum 2).
- REP_DELAY, 50000: cycles from a press pulse to the first auto-repeat pulse.
- REP_PERIOD, 10000: cycles between subsequent auto-repeat pulses.
- KEY_ACTIVE_LOW, 1: 1 means raw key pins read 0 when pressed.
- CNT_W, 16: width of the debounce and repeat counters; must hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD).

Ports:
- clkI  input  1  system clock
- nRstI  input  1  synchronous active-low reset
- keyStartI  input  1  raw start button
- keyStopI  input  1  raw stop button
- keyDirI  input  1  raw direction-toggle button
- keyFreqUpI  input  1  raw frequency-up button
- keyFreqDnI  input  1  raw frequency-down button
- keyPwrUpI  input  1  raw power-up button
- keyPwrDnI  input  1  raw power-down button
- m3startO  output  1  run enable level
- m3forceStopO  output  1  one-cycle stop pulse
- m3invRotateO  output  1  reverse-rotation level
- m3freqINCo  output  1  one-cycle frequency increment pulse
- m3freqDECo  output  1  one-cycle frequency decrement pulse
- m3powerINCo  output  1  one-cycle power increment pulse
- m3powerDECo  output  1  one-cycle power decrement pulse

Behaviour:
- Clock and reset: single clock clkI; reset nRstI is synchronous and active-low, sampled only on the rising edge of clkI.
- Reset state:
  - all outputs 0
  - every synchroniser flop and debounced state = released
  - all counters 0
  - both repeat FSMs in IDLE
- Reset mid-operation: takes effect on the next edge and behaves identically.
- Input conditioning, per key:
  - Polarity normalise via KEY_ACTIVE_LOW; pressed = 1 internally.
  - 2-flop synchroniser.
  - Debounce: when the synchronised value differs from the debounced state, the counter increments. When it reaches DEB_CYCLES, the debounced state flips and the counter clears. Any cycle where the values match clears the counter.
  - Press edge (prs) = one-cycle strobe on the debounced 0->1 transition.
- Latency: raw press held continuously from cycle 0 gives prs in cycle DEB_CYCLES+2 and the registered output pulse in cycle DEB_CYCLES+3.
- Start/stop:
  - prs_start sets m3startO=1; m3startO stays 1 if already 1.
  - prs_stop clears m3startO and drives m3forceStopO=1 for exactly one cycle, also when already stopped.
  - Simultaneous prs_start and prs_stop: stop wins (start=0, forceStop pulse).
- Direction: prs_dir toggles m3invRotateO only while m3startO==0. Ignored while running, including the cycle in which start is being set.
- Auto-repeat: one FSM per axis, freq (Up/Dn) and power (Up/Dn), identical.
  - IDLE: prs on exactly one key of the pair -> emit that key's pulse, load counter 0, go to DELAY; the active key is latched.
  - DELAY: active key held -> count. On reaching REP_DELAY: emit pulse, clear counter, go to REPEAT.
  - REPEAT: active key held -> count. On reaching REP_PERIOD: emit pulse, clear counter.
  - Release of the active key in DELAY or REPEAT -> IDLE, no pulse.
  - Both keys of a pair debounced-pressed in any state -> IDLE, no pulse that cycle, stays IDLE until a fresh single prs.
  - A single prs on both keys in the same cycle -> no pulse.
  - Pulses are generated regardless of m3startO.
  - INC and DEC of one axis are never high in the same cycle.
- All outputs are registered.
- Counters saturate and never wrap.

Decomposition:
- Package m3_cmd_pkg contains:
  - repeat FSM state enum: IDLE, DELAY, REPEAT
  - key index constants 0..6
  - default timing constants
- Sub-module m3_key_debounce, instantiated 7 times:
  - polarity normalise, synchroniser, debounce counter, press-edge strobe
  - outputs: debounced level, prs
- Start/stop/dir logic and the two repeat FSMs live in the top module.

Test Plan:
All tests use DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8, KEY_ACTIVE_LOW=1.
- Reset then idle pins=1 -> all outputs 0 for 100 cycles; keyStartI=0 held from cycle 0 -> m3startO rises in cycle 7 and stays 1.
- keyFreqUpI held low 60 cycles -> m3freqINCo pulses in cycles 7, 27, 35, 43, 51, 59; m3freqDECo never asserts.
- keyPwrDnI with 3-cycle glitches (low 3, high 1, repeated) -> no m3powerDECo pulse; a clean 5-cycle low -> exactly one pulse.
- Running, then keyStartI and keyStopI pressed in the same cycle -> m3startO=0 and a single one-cycle m3forceStopO; keyDirI pressed while running -> m3invRotateO unchanged; pressed after stop -> toggles to 1.
- keyFreqUpI held, then keyFreqDnI also pressed during REPEAT -> no further pulses on either output; releasing Dn alone -> no pulse until Up is released and re-pressed.
- Assert nRstI=0 for one cycle mid-REPEAT with start=1, invRotate=1 -> next cycle all outputs 0; key still held -> new press pulse only after a fresh debounce of DEB_CYCLES+3 cycles.

Source files
------------

// File: rtl/m3_cmd_pkg.sv
// Shared definitions for the m3 front-panel command generator:
// auto-repeat state encoding, key slot numbering and default timing.
package m3_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repState_e;

    localparam int KEY_START = 0;
    localparam int KEY_STOP  = 1;
    localparam int KEY_DIR   = 2;
    localparam int KEY_FUP   = 3;
    localparam int KEY_FDN   = 4;
    localparam int KEY_PUP   = 5;
    localparam int KEY_PDN   = 6;
    localparam int NUM_KEYS  = 7;

    localparam int DEF_DEB_CYCLES     = 1000;
    localparam int DEF_REP_DELAY      = 50000;
    localparam int DEF_REP_PERIOD     = 10000;
    localparam int DEF_KEY_ACTIVE_LOW = 1;
    localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/m3_key_debounce.sv
// Conditions one raw push-button: polarity normalise, 2-flop synchroniser,
// stability counter and a one-cycle strobe when the debounced key goes down.
module m3_key_debounce
    import m3_cmd_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic keyI,
    output logic levelO,
    output logic prsO
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             keyPressed;
    logic             syncA;
    logic             syncB;
    logic             debLvl;
    logic             prsR;
    logic [CNT_W-1:0] debCnt;

    assign keyPressed = (KEY_ACTIVE_LOW != 0) ? ~keyI : keyI;

    // Two-stage synchroniser; both stages reset to the released state.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= keyPressed;
            syncB <= syncA;
        end
    end

    // Accept a new key state only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            debLvl <= 1'b0;
            debCnt <= '0;
            prsR   <= 1'b0;
        end else begin
            prsR <= 1'b0;
            if (syncB != debLvl) begin
                if (debCnt >= DEB_LAST) begin
                    debLvl <= syncB;
                    debCnt <= '0;
                    prsR   <= syncB;
                end else if (debCnt != CNT_MAX) begin
                    debCnt <= debCnt + CNT_W'(1);
                end
            end else begin
                debCnt <= '0;
            end
        end
    end

    assign levelO = debLvl;
    assign prsO   = prsR;

endmodule

// File: rtl/m3_cmd_key_gen.sv
// Front-panel command generator for the 3-phase motor controller.
// Turns seven raw buttons into run/stop/direction levels and pulses plus
// frequency and power step pulses with auto-repeat while a key is held.
module m3_cmd_key_gen
    import m3_cmd_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int REP_DELAY      = DEF_REP_DELAY,
    parameter int REP_PERIOD     = DEF_REP_PERIOD,
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic keyStartI,
    input  logic keyStopI,
    input  logic keyDirI,
    input  logic keyFreqUpI,
    input  logic keyFreqDnI,
    input  logic keyPwrUpI,
    input  logic keyPwrDnI,
    output logic m3startO,
    output logic m3forceStopO,
    output logic m3invRotateO,
    output logic m3freqINCo,
    output logic m3freqDECo,
    output logic m3powerINCo,
    output logic m3powerDECo
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [NUM_KEYS-1:0] keyRaw;
    logic [NUM_KEYS-1:0] keyLvl;
    logic [NUM_KEYS-1:0] keyPrs;
    logic                unusedLvl;

    logic       startR;
    logic       forceStopR;
    logic       invRotR;
    logic       startNext;
    logic       invRotNext;
    logic [1:0] incNextV;
    logic [1:0] decNextV;
    logic [1:0] incR;
    logic [1:0] decR;

    assign keyRaw[KEY_START] = keyStartI;
    assign keyRaw[KEY_STOP]  = keyStopI;
    assign keyRaw[KEY_DIR]   = keyDirI;
    assign keyRaw[KEY_FUP]   = keyFreqUpI;
    assign keyRaw[KEY_FDN]   = keyFreqDnI;
    assign keyRaw[KEY_PUP]   = keyPwrUpI;
    assign keyRaw[KEY_PDN]   = keyPwrDnI;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
        m3_key_debounce #(
            .DEB_CYCLES    (DEB_CYCLES),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
            .CNT_W         (CNT_W)
        ) uDeb (
            .clkI  (clkI),
            .nRstI (nRstI),
            .keyI  (keyRaw[k]),
            .levelO(keyLvl[k]),
            .prsO  (keyPrs[k])
        );
    end

    // Start, stop and direction react to press strobes only, not held levels.
    assign unusedLvl = ^{keyLvl[KEY_START], keyLvl[KEY_STOP], keyLvl[KEY_DIR]};

    // Run level and direction: stop beats start, direction only flips while stopped.
    always_comb begin
        startNext  = startR;
        invRotNext = invRotR;
        if (keyPrs[KEY_STOP]) begin
            startNext = 1'b0;
        end else if (keyPrs[KEY_START]) begin
            startNext = 1'b1;
        end
        if (keyPrs[KEY_DIR] && !startR && !startNext) begin
            invRotNext = ~invRotR;
        end
    end

    // One auto-repeat engine per axis: freq (FUP/FDN) and power (PUP/PDN).
    for (genvar a = 0; a < 2; a++) begin : gAxis
        localparam int UP_IDX = KEY_FUP + 2 * a;
        localparam int DN_IDX = KEY_FDN + 2 * a;

        repState_e        state;
        repState_e        stateNext;
        logic [CNT_W-1:0] repCnt;
        logic [CNT_W-1:0] repCntNext;
        logic             actDn;
        logic             actDnNext;
        logic             incNext;
        logic             decNext;
        logic             upLvl;
        logic             dnLvl;
        logic             upPrs;
        logic             dnPrs;
        logic             actLvl;

        assign upLvl  = keyLvl[UP_IDX];
        assign dnLvl  = keyLvl[DN_IDX];
        assign upPrs  = keyPrs[UP_IDX];
        assign dnPrs  = keyPrs[DN_IDX];
        assign actLvl = actDn ? dnLvl : upLvl;

        // Next state: both keys down always parks the axis in IDLE silently.
        always_comb begin
            stateNext  = state;
            repCntNext = repCnt;
            actDnNext  = actDn;
            incNext    = 1'b0;
            decNext    = 1'b0;
            if (upLvl && dnLvl) begin
                stateNext  = IDLE;
                repCntNext = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (upPrs ^ dnPrs) begin
                            stateNext  = DELAY;
                            repCntNext = '0;
                            actDnNext  = dnPrs;
                            incNext    = upPrs;
                            decNext    = dnPrs;
                        end
                    end
                    DELAY: begin
                        if (!actLvl) begin
                            stateNext  = IDLE;
                            repCntNext = '0;
                        end else if (repCnt >= DELAY_LAST) begin
                            stateNext  = REPEAT;
                            repCntNext = '0;
                            incNext    = !actDn;
                            decNext    = actDn;
                        end else if (repCnt != CNT_MAX) begin
                            repCntNext = repCnt + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!actLvl) begin
                            stateNext  = IDLE;
                            repCntNext = '0;
                        end else if (repCnt >= PERIOD_LAST) begin
                            repCntNext = '0;
                            incNext    = !actDn;
                            decNext    = actDn;
                        end else if (repCnt != CNT_MAX) begin
                            repCntNext = repCnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        stateNext  = IDLE;
                        repCntNext = '0;
                    end
                endcase
            end
        end

        // Repeat state, timer and latched active key.
        always_ff @(posedge clkI) begin
            if (!nRstI) begin
                state  <= IDLE;
                repCnt <= '0;
                actDn  <= 1'b0;
            end else begin
                state  <= stateNext;
                repCnt <= repCntNext;
                actDn  <= actDnNext;
            end
        end

        assign incNextV[a] = incNext;
        assign decNextV[a] = decNext;
    end

    // Every command output leaves the block from a register.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            startR     <= 1'b0;
            forceStopR <= 1'b0;
            invRotR    <= 1'b0;
            incR       <= 2'b00;
            decR       <= 2'b00;
        end else begin
            startR     <= startNext;
            forceStopR <= keyPrs[KEY_STOP];
            invRotR    <= invRotNext;
            incR       <= incNextV;
            decR       <= decNextV;
        end
    end

    assign m3startO     = startR;
    assign m3forceStopO = forceStopR;
    assign m3invRotateO = invRotR;
    assign m3freqINCo   = incR[0];
    assign m3freqDECo   = decR[0];
    assign m3powerINCo  = incR[1];
    assign m3powerDECo  = decR[1];

endmodule

// File: tb/tb_m3_cmd_key_gen.sv
// Self-checking bench for m3_cmd_key_gen: directed scenarios followed by
// random key traffic, all compared cycle by cycle against a behavioural model.
module tb_m3_cmd_key_gen;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 8;
    localparam int CW   = 16;

    logic clkI = 1'b0;
    logic nRstI;
    logic keyStartI, keyStopI, keyDirI;
    logic keyFreqUpI, keyFreqDnI, keyPwrUpI, keyPwrDnI;
    logic m3startO, m3forceStopO, m3invRotateO;
    logic m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo;

    always #5 clkI = ~clkI;

    m3_cmd_key_gen #(
        .DEB_CYCLES    (DEB),
        .REP_DELAY     (RDLY),
        .REP_PERIOD    (RPER),
        .KEY_ACTIVE_LOW(1),
        .CNT_W         (CW)
    ) dut (
        .clkI        (clkI),
        .nRstI       (nRstI),
        .keyStartI   (keyStartI),
        .keyStopI    (keyStopI),
        .keyDirI     (keyDirI),
        .keyFreqUpI  (keyFreqUpI),
        .keyFreqDnI  (keyFreqDnI),
        .keyPwrUpI   (keyPwrUpI),
        .keyPwrDnI   (keyPwrDnI),
        .m3startO    (m3startO),
        .m3forceStopO(m3forceStopO),
        .m3invRotateO(m3invRotateO),
        .m3freqINCo  (m3freqINCo),
        .m3freqDECo  (m3freqDECo),
        .m3powerINCo (m3powerINCo),
        .m3powerDECo (m3powerDECo)
    );

    // Pressed-key bit positions: 0 start,1 stop,2 dir,3 fup,4 fdn,5 pup,6 pdn.
    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;
    int scnBase = 0;

    // Observed-pulse bookkeeping for directed timing checks.
    int freqIncLog[$];
    int freqIncCnt, freqDecCnt, pwrIncCnt, pwrDecCnt, stopCnt;
    int startRise, pwrIncFirst;

    // Behavioural model: values valid in the current cycle.
    logic [6:0]     mS1, mS2, mDeb, mPrs;
    logic [DEB-1:0] mHist [7];
    logic           eStart, eStop, eInv;
    logic [1:0]     eInc, eDec;
    int             axActive [2];
    int             axAge [2];

    task automatic modelReset();
        mS1 = '0; mS2 = '0; mDeb = '0; mPrs = '0;
        for (int k = 0; k < 7; k++) mHist[k] = '0;
        eStart = 1'b0; eStop = 1'b0; eInv = 1'b0;
        eInc = 2'b00; eDec = 2'b00;
        for (int a = 0; a < 2; a++) begin
            axActive[a] = 0;
            axAge[a]    = 0;
        end
    endtask

    // Advance the model by one clock given this cycle's reset and pressed keys.
    task automatic modelStep(input logic rstN, input logic [6:0] p);
        logic [6:0] nDeb, nPrs;
        logic       nStart, nInv, fire;
        logic [1:0] nInc, nDec;
        int         up, dn, actIdx;
        if (!rstN) begin
            modelReset();
            return;
        end
        nDeb = mDeb;
        nPrs = '0;
        for (int k = 0; k < 7; k++) begin
            // A key changes state once its last DEB synced samples all disagree.
            mHist[k] = {mHist[k][DEB-2:0], mS2[k]};
            if (mHist[k] == {DEB{~mDeb[k]}}) begin
                nDeb[k] = ~mDeb[k];
                nPrs[k] = nDeb[k];
            end
        end
        nStart = mPrs[1] ? 1'b0 : (mPrs[0] ? 1'b1 : eStart);
        nInv   = (mPrs[2] && !eStart && !nStart) ? ~eInv : eInv;
        nInc = 2'b00;
        nDec = 2'b00;
        for (int a = 0; a < 2; a++) begin
            up = 3 + 2 * a;
            dn = 4 + 2 * a;
            fire = 1'b0;
            if (mDeb[up] && mDeb[dn]) begin
                axActive[a] = 0;
            end else if (axActive[a] == 0) begin
                if (mPrs[up] != mPrs[dn]) begin
                    axActive[a] = mPrs[up] ? 1 : 2;
                    axAge[a]    = 0;
                    fire        = 1'b1;
                end
            end else begin
                actIdx = (axActive[a] == 1) ? up : dn;
                if (!mDeb[actIdx]) begin
                    axActive[a] = 0;
                end else begin
                    axAge[a]++;
                    fire = (axAge[a] == RDLY) ||
                           (axAge[a] > RDLY && ((axAge[a] - RDLY) % RPER) == 0);
                end
            end
            if (fire) begin
                nInc[a] = (axActive[a] == 1);
                nDec[a] = (axActive[a] == 2);
            end
        end
        eStop  = mPrs[1];
        eStart = nStart;
        eInv   = nInv;
        eInc   = nInc;
        eDec   = nDec;
        mS2    = mS1;
        mS1    = p;
        mDeb   = nDeb;
        mPrs   = nPrs;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Compare all outputs with the model and log pulses for directed checks.
    task automatic checkOutput();
        chk("start",     m3startO,     eStart);
        chk("forceStop", m3forceStopO, eStop);
        chk("invRotate", m3invRotateO, eInv);
        chk("freqINC",   m3freqINCo,   eInc[0]);
        chk("freqDEC",   m3freqDECo,   eDec[0]);
        chk("powerINC",  m3powerINCo,  eInc[1]);
        chk("powerDEC",  m3powerDECo,  eDec[1]);
        if (m3freqINCo) begin
            freqIncCnt++;
            freqIncLog.push_back(cyc - scnBase);
        end
        if (m3freqDECo) freqDecCnt++;
        if (m3powerINCo) begin
            pwrIncCnt++;
            if (pwrIncFirst < 0) pwrIncFirst = cyc - scnBase;
        end
        if (m3powerDECo) pwrDecCnt++;
        if (m3forceStopO) stopCnt++;
        if (m3startO && startRise < 0) startRise = cyc - scnBase;
    endtask

    // Drive one cycle of pins (pressed keys pull the pin low), clock it, check.
    task automatic applyStimulus(input logic rstN, input logic [6:0] p);
        nRstI      = rstN;
        keyStartI  = ~p[0];
        keyStopI   = ~p[1];
        keyDirI    = ~p[2];
        keyFreqUpI = ~p[3];
        keyFreqDnI = ~p[4];
        keyPwrUpI  = ~p[5];
        keyPwrDnI  = ~p[6];
        @(posedge clkI);
        modelStep(rstN, p);
        @(negedge clkI);
        cyc++;
        checkOutput();
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, p);
    endtask

    task automatic clearLogs();
        scnBase = cyc;
        freqIncLog.delete();
        freqIncCnt = 0; freqDecCnt = 0; pwrIncCnt = 0; pwrDecCnt = 0;
        stopCnt = 0; startRise = -1; pwrIncFirst = -1;
    endtask

    initial begin
        int expInc [6] = '{7, 27, 35, 43, 51, 59};
        logic [6:0] rp;
        modelReset();
        clearLogs();

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7'h00);
        hold(7'h00, 100);

        $display("[TB] start press latency");
        clearLogs();
        hold(7'b0000001, 20);
        hold(7'h00, 10);
        chkInt("start_rise_cycle", startRise, DEB + 3);
        chk("start_held", m3startO, 1'b1);

        $display("[TB] freq up auto-repeat");
        clearLogs();
        hold(7'b0001000, 60);
        hold(7'h00, 20);
        chkInt("freq_inc_count", freqIncLog.size(), 6);
        for (int i = 0; i < 6 && i < freqIncLog.size(); i++)
            chkInt("freq_inc_cycle", freqIncLog[i], expInc[i]);
        chkInt("freq_dec_count", freqDecCnt, 0);

        $display("[TB] power down glitches");
        clearLogs();
        for (int r = 0; r < 5; r++) begin
            hold(7'b1000000, 3);
            hold(7'h00, 1);
        end
        hold(7'h00, 10);
        chkInt("glitch_no_pulse", pwrDecCnt, 0);
        hold(7'b1000000, 5);
        hold(7'h00, 30);
        chkInt("clean_one_pulse", pwrDecCnt, 1);

        $display("[TB] direction and stop");
        clearLogs();
        hold(7'b0000100, 10);
        hold(7'h00, 10);
        chk("dir_ignored_running", m3invRotateO, 1'b0);
        hold(7'b0000011, 10);
        hold(7'h00, 10);
        chk("stop_wins", m3startO, 1'b0);
        chkInt("stop_pulse_count", stopCnt, 1);
        hold(7'b0000100, 10);
        hold(7'h00, 10);
        chk("dir_toggled_stopped", m3invRotateO, 1'b1);

        $display("[TB] both keys of an axis");
        hold(7'b0000001, 10);
        hold(7'h00, 10);
        clearLogs();
        hold(7'b0001000, 40);
        freqIncCnt = 0;
        freqDecCnt = 0;
        hold(7'b0011000, 30);
        hold(7'b0001000, 30);
        chkInt("both_inc_count", freqIncCnt, 1);
        chkInt("both_dec_count", freqDecCnt, 0);
        hold(7'h00, 15);
        hold(7'b0001000, 10);
        chkInt("repress_inc_count", freqIncCnt, 2);
        hold(7'h00, 15);

        $display("[TB] reset mid-repeat");
        clearLogs();
        hold(7'b0100000, 36);
        chk("pre_reset_start", m3startO, 1'b1);
        chk("pre_reset_inv", m3invRotateO, 1'b1);
        applyStimulus(1'b0, 7'b0100000);
        chk("post_reset_start", m3startO, 1'b0);
        chk("post_reset_inv", m3invRotateO, 1'b0);
        chk("post_reset_pinc", m3powerINCo, 1'b0);
        clearLogs();
        hold(7'b0100000, 15);
        chkInt("reset_redebounce", pwrIncFirst, DEB + 3);
        hold(7'h00, 15);

        $display("[TB] random traffic");
        for (int s = 0; s < 150; s++) begin
            rp = '0;
            for (int k = 0; k < 7; k++) rp[k] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) applyStimulus(1'b0, rp);
            hold(rp, $urandom_range(1, 35));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
